// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  localparam int INSTR_W   = 16;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    ST_HDR_HI  = 3'd0,
    ST_HDR_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_WRITE   = 3'd4,
    ST_CSUM    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

  // States in which the loader will take a byte from the stream
  function automatic logic rx_open(input loader_state_t s);
    logic r;
    case (s)
      ST_HDR_HI, ST_HDR_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM: r = 1'b1;
      default:                                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/loader_csum.sv
// Mod-256 byte sum over the load stream, with clear, enable and a compare output.
module loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum,
  output logic       o_match
);

  logic [7:0] r_sum;

  // Accumulator, cleared by reset or a reload request
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sum <= 8'd0;
    end else if (i_clr) begin
      r_sum <= 8'd0;
    end else if (i_en) begin
      r_sum <= r_sum + i_byte;
    end else begin
      r_sum <= r_sum;
    end
  end

  assign o_sum   = r_sum;
  assign o_match = (r_sum == i_byte);

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: fills instruction memory and holds the CPU until done.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loader_state_t FINISH_ST = ST_CSUM;
`else
  localparam loader_state_t FINISH_ST = ST_DONE;
`endif

  loader_state_t      r_state;
  loader_state_t      w_next;
  logic [15:0]        r_n;
  logic [7:0]         r_hi;
  logic [ADDR_W:0]    r_idx;
  logic               r_rx_ready, r_imem_we, r_cpu_hold, r_load_done, r_load_err;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic [INSTR_W-1:0] r_imem_wdata;

  logic        w_accept, w_last, w_restart, w_csum_ok;
  logic [15:0] w_hdr_n;

  assign w_accept  = rx_valid && r_rx_ready;
  assign w_hdr_n   = {r_n[15:8], rx_data};
  assign w_last    = (17'(r_idx) + 17'd1) == {1'b0, r_n};
  assign w_restart = ((r_state == ST_DONE) || (r_state == ST_ERR)) && start;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic       w_sum_en;
  logic [7:0] w_sum;

  assign w_sum_en = w_accept && (r_state inside {ST_HDR_HI, ST_HDR_LO, ST_DATA_HI, ST_DATA_LO});

  loader_csum u_csum (
    .clk     (CLK),
    .rst     (rst),
    .i_clr   (w_restart),
    .i_en    (w_sum_en),
    .i_byte  (rx_data),
    .o_sum   (w_sum),
    .o_match (w_csum_ok)
  );
`else
  assign w_csum_ok = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_HDR_HI:  if (w_accept) w_next = ST_HDR_LO; else w_next = r_state;
      ST_HDR_LO: begin
        if (!w_accept)                           w_next = r_state;
        else if (w_hdr_n == 16'd0)               w_next = FINISH_ST;
        else if ({1'b0, w_hdr_n} > MAX_WORDS)    w_next = ST_ERR;
        else                                     w_next = ST_DATA_HI;
      end
      ST_DATA_HI: if (w_accept) w_next = ST_DATA_LO; else w_next = r_state;
      ST_DATA_LO: if (w_accept) w_next = ST_WRITE;   else w_next = r_state;
      ST_WRITE:   if (w_last)   w_next = FINISH_ST;  else w_next = ST_DATA_HI;
      ST_CSUM: begin
        if (!w_accept)      w_next = r_state;
        else if (w_csum_ok) w_next = ST_DONE;
        else                w_next = ST_ERR;
      end
      ST_DONE, ST_ERR: if (start) w_next = ST_HDR_HI; else w_next = r_state;
      default:    w_next = ST_HDR_HI;
    endcase
  end

  // State, datapath and registered outputs; status flags follow the next state
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state      <= ST_HDR_HI;
      r_n          <= 16'd0;
      r_hi         <= 8'd0;
      r_idx        <= '0;
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_rx_ready  <= rx_open(w_next);
      r_imem_we   <= (r_state == ST_DATA_LO) && w_accept;
      r_cpu_hold  <= (w_next != ST_DONE);
      r_load_done <= (w_next == ST_DONE);
      r_load_err  <= (w_next == ST_ERR);
      if ((r_state == ST_HDR_HI) && w_accept) r_n[15:8] <= rx_data;
      if ((r_state == ST_HDR_LO) && w_accept) r_n <= w_hdr_n;
      if ((r_state == ST_DATA_HI) && w_accept) r_hi <= rx_data;
      if ((r_state == ST_DATA_LO) && w_accept) begin
        r_imem_addr  <= r_idx[ADDR_W-1:0];
        r_imem_wdata <= {r_hi, rx_data};
      end
      if (r_state == ST_WRITE) r_idx <= r_idx + 1'b1;
      if (w_restart) begin
        r_idx <= '0;
        r_n   <= 16'd0;
      end
    end
  end

  assign rx_ready   = r_rx_ready;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader; also covers PROG_LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam logic [15:0] EXP_DATA [3] = '{16'h8008, 16'h8101, 16'hFFFF};

  logic              CLK = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_ready, imem_we, cpu_hold, load_done, load_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;
  int wcount = 0;
  logic [7:0]  wr_addr [64];
  logic [15:0] wr_data [64];
  logic [7:0]  sbuf [9];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write log; the loader must not take bytes or release the CPU while writing
  always @(negedge CLK) begin
    if (imem_we === 1'b1) begin
      if (wcount < 64) begin
        wr_addr[wcount] = imem_addr;
        wr_data[wcount] = imem_wdata;
      end
      wcount++;
      last_we_cyc = cyc;
      chk("ready_in_write", 32'(rx_ready), 32'd0);
      chk("hold_in_write", 32'(cpu_hold), 32'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) @(negedge CLK);
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 40 && rx_ready !== 1'b1; i++) @(negedge CLK);
    chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int n, input int gap_max);
    for (int i = 0; i < n; i++)
      send_byte(sbuf[i], (gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0)));
  endtask

  task automatic load3(input int gap_max);
    sbuf[0] = 8'h00; sbuf[1] = 8'h03; sbuf[2] = 8'h80; sbuf[3] = 8'h08;
    sbuf[4] = 8'h81; sbuf[5] = 8'h01; sbuf[6] = 8'hFF; sbuf[7] = 8'hFF;
    sbuf[8] = 8'h0B;
`ifdef PROG_LOADER_CHECKSUM_EN
    send_stream(9, gap_max);
`else
    send_stream(8, gap_max);
`endif
  endtask

  // Waits for load_done or load_err; returns the number of falling edges waited
  task automatic wait_end(output int waited);
    waited = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      waited++;
      if (load_done === 1'b1 || load_err === 1'b1) break;
    end
    chk("end_reached", 32'(load_done | load_err), 32'd1);
  endtask

  task automatic check_writes3(input int base);
    chk("wr_count", 32'(wcount - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("wr_addr", 32'(wr_addr[base + i]), 32'(i));
      chk("wr_data", 32'(wr_data[base + i]), 32'(EXP_DATA[i]));
    end
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    @(negedge CLK);
    chk("restart_hold", 32'(cpu_hold), 32'd1);
    chk("restart_done", 32'(load_done), 32'd0);
    chk("restart_err", 32'(load_err), 32'd0);
    chk("restart_ready", 32'(rx_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int waited;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    rst = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", 32'(rx_ready), 32'd1);

    // Three-word load, back-to-back bytes
    base = wcount;
    load3(0);
    wait_end(waited);
    check_writes3(base);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_err", 32'(load_err), 32'd0);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
`ifndef PROG_LOADER_CHECKSUM_EN
    chk("t1_done_delay", 32'(cyc - last_we_cyc), 32'd1);
`endif
    pulse_start();

    // Empty program
    base = wcount;
    sbuf[0] = 8'h00; sbuf[1] = 8'h00; sbuf[2] = 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
    send_stream(3, 0);
`else
    send_stream(2, 0);
`endif
    wait_end(waited);
    chk("t2_wait", 32'(waited), 32'd1);
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_writes", 32'(wcount - base), 32'd0);
    pulse_start();

    // Oversize header (257 words)
    base = wcount;
    sbuf[0] = 8'h01; sbuf[1] = 8'h01;
    send_stream(2, 0);
    wait_end(waited);
    chk("t3_wait", 32'(waited), 32'd1);
    chk("t3_err", 32'(load_err), 32'd1);
    chk("t3_done", 32'(load_done), 32'd0);
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    chk("t3_writes", 32'(wcount - base), 32'd0);
    pulse_start();

    // Same load with random valid gaps
    base = wcount;
    load3(5);
    wait_end(waited);
    check_writes3(base);
    chk("t4_done", 32'(load_done), 32'd1);
    pulse_start();

`ifdef PROG_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    base = wcount;
    sbuf[0] = 8'h00; sbuf[1] = 8'h01; sbuf[2] = 8'h12; sbuf[3] = 8'h34; sbuf[4] = 8'h47;
    send_stream(5, 0);
    wait_end(waited);
    chk("t5_done", 32'(load_done), 32'd1);
    chk("t5_writes", 32'(wcount - base), 32'd1);
    chk("t5_data", 32'(wr_data[base]), 32'h1234);
    pulse_start();
    base = wcount;
    sbuf[4] = 8'h48;
    send_stream(5, 0);
    wait_end(waited);
    chk("t6_err", 32'(load_err), 32'd1);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_writes", 32'(wcount - base), 32'd1);
    chk("t6_addr", 32'(wr_addr[base]), 32'd0);
    chk("t6_data", 32'(wr_data[base]), 32'h1234);
    pulse_start();
`endif

    // Reset in the middle of a load, then a full reload
    sbuf[0] = 8'h00; sbuf[1] = 8'h03; sbuf[2] = 8'h80; sbuf[3] = 8'h08;
    send_stream(4, 0);
    @(negedge CLK);
    rst = 1'b0;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("mid_rst_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(imem_wdata), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_done", 32'(load_done), 32'd0);
    chk("mid_rst_err", 32'(load_err), 32'd0);
    rst = 1'b1;
    @(negedge CLK);
    chk("mid_rst_ready_up", 32'(rx_ready), 32'd1);
    base = wcount;
    load3(0);
    wait_end(waited);
    check_writes3(base);
    chk("t7_done", 32'(load_done), 32'd1);
    chk("t7_hold", 32'(cpu_hold), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
